// File: rtl/cmprs_frame_sequencer.sv
// cmprs_frame_sequencer: per-channel compressor frame sequencer (start, read, drain, flush, done).
// Define CMPRS_SEQ_TIMEOUT_EN to compile in the per-frame watchdog.
module cmprs_frame_sequencer #(
   parameter int FRAME_BITS   = 4,
   parameter int TIMEOUT_BITS = 20
) (
   input  logic                  mclk,
   input  logic                  mrst,
   input  logic                  cmprs_en,
   input  logic                  frame_start,
   input  logic                  mem_done,
   input  logic                  stuffer_running,
   input  logic                  eof_written,
   input  logic                  irq_clr,
   output logic                  read_start,
   output logic [2:0]            status,
   output logic                  frame_done,
   output logic [FRAME_BITS-1:0] frame_num,
   output logic [1:0]            pending,
   output logic                  irq,
   output logic                  overrun,
   output logic                  timeout
);
   typedef enum logic [2:0] {IDLE, START, READ, DRAIN, FLUSH, DONE} state_t;
   state_t state, state_nxt;
   logic   seen_run, stuffer_r, deq, enq, drop, expire, active;

   assign active = state == READ || state == DRAIN || state == FLUSH;

`ifdef CMPRS_SEQ_TIMEOUT_EN
   logic [TIMEOUT_BITS-1:0] wd;
   assign expire = active && &wd;
   always_ff @(posedge mclk) begin
      if (mrst || state == START) wd <= '0;
      else if (active) wd <= wd + 1'b1;
      if (mrst || !cmprs_en) timeout <= 1'b0;
      else if (expire) timeout <= 1'b1;
   end
`else
   assign expire  = 1'b0;
   assign timeout = TIMEOUT_BITS < 0;
`endif

   always_comb begin
      state_nxt = state;
      deq       = 1'b0;
      case (state)
         IDLE:    if (frame_start || pending != 2'd0) begin
                     state_nxt = START;
                     deq       = pending != 2'd0;
                  end
         START:   state_nxt = READ;
         READ:    if (mem_done) state_nxt = DRAIN;
         DRAIN:   if (seen_run && !stuffer_running) state_nxt = eof_written ? DONE : FLUSH;
         FLUSH:   if (eof_written) state_nxt = DONE;
         DONE:    begin
                     state_nxt = pending != 2'd0 ? START : IDLE;
                     deq       = pending != 2'd0;
                  end
         default: state_nxt = IDLE;
      endcase
      if (!cmprs_en || expire) begin
         state_nxt = IDLE;
         deq       = 1'b0;
      end
   end

   // A request in IDLE is served directly unless older requests are already queued
   assign enq  = cmprs_en && frame_start && (state != IDLE || pending != 2'd0);
   assign drop = enq && !deq && pending == 2'd2;

   always_ff @(posedge mclk) begin
      if (mrst) begin
         state      <= IDLE;
         pending    <= '0;
         frame_num  <= '0;
         frame_done <= 1'b0;
         irq        <= 1'b0;
         overrun    <= 1'b0;
         seen_run   <= 1'b0;
         stuffer_r  <= 1'b0;
      end else begin
         state      <= state_nxt;
         pending    <= (!cmprs_en || expire) ? 2'd0 : pending + {1'b0, enq && !drop} - {1'b0, deq};
         frame_done <= state_nxt == DONE;
         if (state_nxt == DONE) frame_num <= frame_num + 1'b1;
         irq        <= state_nxt == DONE || (irq && !(irq_clr && !frame_done));
         overrun    <= drop || (overrun && !irq_clr);
         seen_run   <= state != START && (seen_run || (stuffer_running && (state == READ || state == DRAIN)));
         stuffer_r  <= stuffer_running;
      end
   end

   assign read_start = state == START;
   assign status     = {state == FLUSH, stuffer_r, state == READ};
endmodule
